// File: rtl/st_msg_serializer.sv
// Message byte serializer: frames an accepted MSG3/MSG4 as type byte, availability
// bitmap, then every available field's bytes (most significant byte first).
package st_msg_pkg;
  typedef logic [7:0] msg_type_t;

  localparam msg_type_t MSG3_TYPE = 8'h04;
  localparam msg_type_t MSG4_TYPE = 8'h06;

  typedef struct packed {
    logic            field0_avail;
    logic [8:0][7:0] field0;
    logic            field1_avail;
    logic [2:0][7:0] field1;
    logic            Z_avail;
    logic [5:0][7:0] Z;
    logic            field2_avail;
    logic [4:0][7:0] field2;
    logic            field3_avail;
    logic [3:0][7:0] field3;
  } MSG3_fields;

  typedef struct packed {
    logic            field0_avail;
    logic [8:0][7:0] field0;
    logic            field1_avail;
    logic [2:0][7:0] field1;
    logic            Z_avail;
    logic [5:0][7:0] Z;
    logic            field2_avail;
    logic [4:0][7:0] field2;
    logic            field3_avail;
    logic [2:0][7:0] field3;
  } MSG4_fields;
endpackage

module st_msg_serializer
  import st_msg_pkg::*;
#(
  parameter bit EMIT_EMPTY = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  msg_type_t  in_msg_type,
  input  MSG3_fields in_msg3,
  input  MSG4_fields in_msg4,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       out_last,
  output logic       err_unsupported,
  output logic [1:0] dbg_state
);
  // Handshakes: a transfer happens on a rising edge where valid && ready; a
  // producer holding valid keeps its data stable until that transfer.
  typedef enum logic [1:0] {IDLE, TYPE, MAP, FIELD} state_t;

  state_t          state, state_nx;
  logic            ready_en;
  msg_type_t       type_r;
  logic [4:0]      avail_r;
  logic [8:0][7:0] fld_r [5];
  logic [3:0]      f3_len_r;
  logic [2:0]      cur_r;
  logic [3:0]      cnt_r;
  logic            err_r;

  logic            is_msg3, is_msg4, supported, accept, take, fire, field_end;
  logic [4:0]      in_avail, rest;
  logic [8:0][7:0] in_fld [5];
  logic [3:0]      cur_len, byte_idx;
  logic [5:0]      done_mask;

  // Lowest set bit wins: fields leave in order field0, field1, Z, field2, field3.
  function automatic logic [2:0] lowest(input logic [4:0] m);
    lowest = 3'd0;
    for (int i = 4; i >= 0; i--)
      if (m[i]) lowest = 3'(i);
  endfunction

  assign is_msg3   = (in_msg_type == MSG3_TYPE);
  assign is_msg4   = (in_msg_type == MSG4_TYPE);
  assign supported = is_msg3 || is_msg4;
  assign accept    = in_valid && in_ready;
  assign take      = supported && ((|in_avail) || EMIT_EMPTY);
  assign fire      = out_valid && out_ready;
  assign dbg_state = state;
  assign err_unsupported = err_r;

  always_comb begin
    for (int i = 0; i < 5; i++) in_fld[i] = '0;
    if (is_msg3) begin
      in_avail  = {in_msg3.field3_avail, in_msg3.field2_avail, in_msg3.Z_avail,
                   in_msg3.field1_avail, in_msg3.field0_avail};
      in_fld[0] = in_msg3.field0;
      in_fld[1] = {48'h0, in_msg3.field1};
      in_fld[2] = {24'h0, in_msg3.Z};
      in_fld[3] = {32'h0, in_msg3.field2};
      in_fld[4] = {40'h0, in_msg3.field3};
    end else begin
      in_avail  = {in_msg4.field3_avail, in_msg4.field2_avail, in_msg4.Z_avail,
                   in_msg4.field1_avail, in_msg4.field0_avail};
      in_fld[0] = in_msg4.field0;
      in_fld[1] = {48'h0, in_msg4.field1};
      in_fld[2] = {24'h0, in_msg4.Z};
      in_fld[3] = {32'h0, in_msg4.field2};
      in_fld[4] = {48'h0, in_msg4.field3};
    end
  end

  always_comb begin
    case (cur_r)
      3'd0:    cur_len = 4'd9;
      3'd1:    cur_len = 4'd3;
      3'd2:    cur_len = 4'd6;
      3'd3:    cur_len = 4'd5;
      3'd4:    cur_len = f3_len_r;
      default: cur_len = 4'd1;
    endcase
  end

  assign byte_idx  = cur_len - 4'd1 - cnt_r;
  assign field_end = (cnt_r == cur_len - 4'd1);
  // Flags of fields strictly after the current one.
  assign done_mask = (6'd2 << cur_r) - 6'd1;
  assign rest      = avail_r & ~done_mask[4:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_data  = 8'h00;
    out_last  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = ready_en;
        if (accept && take) state_nx = TYPE;
      end
      TYPE: begin
        out_valid = 1'b1;
        out_data  = type_r;
        if (out_ready) state_nx = MAP;
      end
      MAP: begin
        out_valid = 1'b1;
        out_data  = {3'b000, avail_r};
        out_last  = (avail_r == 5'd0);
        if (out_ready) state_nx = (avail_r == 5'd0) ? IDLE : FIELD;
      end
      FIELD: begin
        out_valid = 1'b1;
        out_data  = fld_r[cur_r][byte_idx];
        out_last  = field_end && (rest == 5'd0);
        if (out_ready && field_end && (rest == 5'd0)) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ready_en <= 1'b0;
      type_r   <= '0;
      avail_r  <= '0;
      f3_len_r <= '0;
      cur_r    <= '0;
      cnt_r    <= '0;
      err_r    <= 1'b0;
      for (int i = 0; i < 5; i++) fld_r[i] <= '0;
    end else begin
      ready_en <= 1'b1;
      err_r    <= accept && !supported;
      if (accept && supported) begin
        type_r   <= in_msg_type;
        avail_r  <= in_avail;
        f3_len_r <= is_msg3 ? 4'd4 : 4'd3;
        for (int i = 0; i < 5; i++) fld_r[i] <= in_fld[i];
      end
      if (state == MAP && fire) begin
        cur_r <= lowest(avail_r);
        cnt_r <= 4'd0;
      end
      if (state == FIELD && fire) begin
        if (field_end) begin
          cur_r <= lowest(rest);
          cnt_r <= 4'd0;
        end else begin
          cnt_r <= cnt_r + 4'd1;
        end
      end
    end
  end
endmodule

// File: doc/st_msg_serializer.md
# st_msg_serializer

Byte serializer that sits directly downstream of the message-field stage in the streaming encoder. It accepts one decoded message per handshake, either MSG3 (type 4) or MSG4 (type 6), carried as the package field structs. It emits the message as a framed byte stream: type byte, availability bitmap, then the bytes of every available field. Unsupported types are dropped and flagged.

## Interface
- `EMIT_EMPTY`, default 1: 1 = emit a 2-byte frame when no field is available; 0 = drop such messages silently (no error).
- `clk` in 1: clock, all logic on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `in_valid` in 1: message present.
- `in_ready` out 1: block can accept a message.
- `in_msg_type` in 8 (`msg_type_t`): message type code.
- `in_msg3` in `MSG3_fields`: field payload, used when type = 4.
- `in_msg4` in `MSG4_fields`: field payload, used when type = 6.
- `out_valid` out 1: output byte valid.
- `out_ready` in 1: sink accepts byte.
- `out_data` out 8: output byte.
- `out_last` out 1: marks the final byte of a frame.
- `err_unsupported` out 1: one-cycle pulse when an unsupported type is dropped.

## Operation
- States: IDLE, TYPE, MAP, FIELD.
- IDLE:
  - `in_ready` = 1. On `in_valid && in_ready`, latch the type, the 5 avail flags and all field bytes into internal registers.
  - field3 is normalised to 4 bytes, with its length recorded as 4 (MSG3) or 3 (MSG4).
- Transitions out of IDLE:
  - Supported type with at least one avail flag set → TYPE.
  - Supported type with no avail flags: EMIT_EMPTY=1 → TYPE; EMIT_EMPTY=0 → stay in IDLE, nothing emitted.
  - Unsupported type → stay in IDLE and pulse `err_unsupported` in the following cycle.
- Frame bytes:
  - TYPE: `out_data` = type code (0x04 or 0x06).
  - MAP: `out_data` = {3'b0, field3_avail, field2_avail, Z_avail, field1_avail, field0_avail}.
  - FIELD: fields go in order field0, field1, Z, field2, field3, skipping unavailable ones.
  - Within a field, the highest byte index goes first (field0[8] … field0[0]).
  - Field lengths: 9, 3, 6, 5, then 4 (MSG3) or 3 (MSG4).
- State advance happens only on `out_valid && out_ready`:
  - TYPE → MAP.
  - MAP → FIELD at the first available field, or → IDLE if none is available.
  - FIELD: a byte counter runs 0..len-1. At the end of a field, select the next available field through a priority encoder over the remaining flags, with no idle cycle in between. After the last available field → IDLE.
- `out_last` = 1 on the MAP byte when no field is available; otherwise on the final byte of the last available field. It is 0 on every other byte.
- Maximum frame length: 29 bytes (MSG3) or 28 bytes (MSG4).
- Only one message is in flight at a time. `in_ready` = 0 in TYPE, MAP and FIELD.

## Timing
- Reset values: `in_ready`=0 while `rst`=1 and 1 from the first cycle after release. `out_valid`=0, `out_data`=0x00, `out_last`=0, `err_unsupported`=0, state = IDLE, all counters 0.
- Latency: when a message is accepted in cycle N, `out_valid`=1 with the type byte in cycle N+1.
- Throughput: with `out_ready` held high, one byte per cycle with no bubbles, including across skipped fields. A new message can be accepted in the cycle after the `out_last` handshake, so there is exactly 1 idle output cycle between frames.
- Output stability: while `out_valid && !out_ready`, `out_data` and `out_last` hold stable. `out_valid` never drops before its handshake.
- `in_*` values are sampled only at acceptance. Later changes to them do not affect the frame in progress.
- Reset asserted mid-frame: outputs return to reset values immediately. The partial frame is abandoned without `out_last`, and no error is raised.
- Dropped messages: an unsupported message, or an empty one with EMIT_EMPTY=0, is consumed in 1 cycle. `in_ready` stays 1 in the next cycle, so back-to-back dropped messages are accepted every cycle.
- `err_unsupported` pulses once per dropped unsupported message.

## Test plan
- MSG3, all avail = 1, field0 = 0x01..0x09 with [0]=0x01, `out_ready`=1:
  - 29 contiguous bytes: 0x04, 0x1F, 0x09, 0x08, … 0x01, then field1, Z, field2 and field3 (4 bytes).
  - `out_last` set only on byte 29. First byte appears 1 cycle after acceptance.
- MSG4, only Z and field3 available:
  - Bytes: 0x06, 0x14, Z[5]..Z[0], field3[2]..field3[0].
  - 11 bytes with no bubble between Z and field3. `out_last` on field3[0].
- MSG3 with no fields available:
  - EMIT_EMPTY=1 → bytes 0x04, 0x00, with `out_last` on 0x00.
  - EMIT_EMPTY=0 → no output and no error.
- `in_msg_type`=0x05, then a valid MSG4 in the next cycle:
  - `err_unsupported` pulses once and nothing is emitted for 0x05.
  - The MSG4 is accepted on the next cycle and its frame starts with 0x06.
- Random `out_ready` backpressure (about 50% low) on a full MSG4:
  - Byte sequence identical to the no-backpressure case.
  - `out_data` and `out_last` stable throughout every stall.
  - `in_ready`=0 until after `out_last` is accepted.
- Assert `rst` at byte 10 of a MSG3 frame, release, then send a MSG4:
  - `out_valid` drops within the reset cycle.
  - The post-reset frame starts cleanly with 0x06, and all outputs hold reset values while `rst`=1.
